// File: rtl/input_debounce_sync_pkg.sv
// Shared definitions for the input debounce/synchroniser front end:
// state encodings and default parameter values.
`timescale 1ns/1ps
package input_debounce_sync_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Gray-ordered so each legal transition flips a single bit.
    typedef logic [1:0] state_t;

    localparam state_t ST_LOW       = 2'b00;
    localparam state_t ST_RISE_WAIT = 2'b01;
    localparam state_t ST_HIGH      = 2'b11;
    localparam state_t ST_FALL_WAIT = 2'b10;

    // The two WAIT states are exactly those whose bits differ.
    function automatic logic is_wait(state_t s);
        return s[1] ^ s[0];
    endfunction

endpackage

// File: rtl/input_debounce_sync_sync_chain.sv
// Multi-flop synchroniser for one asynchronous input. Reusable for any
// async level signal; output is the last stage of the chain.
`timescale 1ns/1ps
module sync_chain
    import input_debounce_sync_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic Clk,
    input  logic nReset,
    input  logic AsyncIn,
    output logic SyncOut
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input in at stage 0; reset empties the chain to 0.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], AsyncIn};
        end
    end

    assign SyncOut = sync_q[STAGES-1];

endmodule

// File: rtl/input_debounce_sync.sv
// Debounces a synchronised raw input into a clean Level with one-cycle
// Rise/Fall strobes. A change is accepted only after the synchronised
// input holds its new value for DEBOUNCE_CYCLES consecutive cycles.
`timescale 1ns/1ps
module input_debounce_sync
    import input_debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic nReset,
    input  logic RawIn,
    output logic Level,
    output logic Rise,
    output logic Fall,
    output logic Busy
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncd;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, rise_d, fall_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk     (Clk),
        .nReset  (nReset),
        .AsyncIn (RawIn),
        .SyncOut (syncd)
    );

    // Next-state logic: qualify a candidate change, drop back on any reversal.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = Level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (syncd) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RISE_WAIT: begin
                if (!syncd) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!syncd) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_FALL_WAIT: begin
                if (syncd) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and all outputs are registered; reset aborts any qualify.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            Level   <= 1'b0;
            Rise    <= 1'b0;
            Fall    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Level   <= level_d;
            Rise    <= rise_d;
            Fall    <= fall_d;
            Busy    <= is_wait(state_d);
        end
    end

endmodule
